// File: rtl/ddr3_ring_scheduler_if.sv
// FIFO, MIG user-interface and status bundle for ddr3_ring_scheduler.
// master = scheduler side, slave = FIFOs / MIG / host side.
interface ddr3_ring_scheduler_if #(
  parameter int RING_LOG2 = 20
);
  logic                 calib_done;
  logic                 enable;
  logic                 ib_valid;
  logic [255:0]         ib_data;
  logic                 ib_re;
  logic [6:0]           ob_count;
  logic                 ob_we;
  logic [255:0]         ob_data;
  logic                 app_rdy;
  logic                 app_en;
  logic [2:0]           app_cmd;
  logic [29:0]          app_addr;
  logic                 app_wdf_rdy;
  logic                 app_wdf_wren;
  logic                 app_wdf_end;
  logic [255:0]         app_wdf_data;
  logic [31:0]          app_wdf_mask;
  logic [255:0]         app_rd_data;
  logic                 app_rd_data_valid;
  logic [RING_LOG2:0]   fill_level;
  logic [7:0]           rd_outstanding;
  logic                 busy;
  logic [31:0]          wr_cmd_total;
  logic [31:0]          rd_cmd_total;
  logic [31:0]          stall_cycles;

  modport master (
    input  calib_done, enable, ib_valid, ib_data, ob_count,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output ib_re, ob_we, ob_data, app_en, app_cmd, app_addr,
           app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
           fill_level, rd_outstanding, busy,
           wr_cmd_total, rd_cmd_total, stall_cycles
  );

  modport slave (
    output calib_done, enable, ib_valid, ib_data, ob_count,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  ib_re, ob_we, ob_data, app_en, app_cmd, app_addr,
           app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
           fill_level, rd_outstanding, busy,
           wr_cmd_total, rd_cmd_total, stall_cycles
  );
endinterface

// File: rtl/ddr3_ring_scheduler.sv
// DDR3 ring-buffer scheduler: input FIFO -> MIG ring -> output FIFO.
// Define DDR3_SCHED_STATS_EN to add command/stall statistics counters.
module ddr3_ring_scheduler #(
  parameter int RING_LOG2 = 20,
  parameter int ADDR_BASE = 0,
  parameter int ADDR_STEP = 8,
  parameter int MAX_RUN   = 16,
  parameter int OB_CAP    = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  ddr3_ring_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2
  } state_t;

  localparam logic [29:0]          BASE     = 30'(ADDR_BASE);
  localparam logic [29:0]          STEP     = 30'(ADDR_STEP);
  localparam logic [8:0]           CAP      = 9'(OB_CAP);
  localparam logic [15:0]          RUN_MAX  = 16'(MAX_RUN);
  localparam logic [RING_LOG2:0]   FILL_ONE = (RING_LOG2+1)'(1);
  localparam logic [RING_LOG2-1:0] PTR_ONE  = (RING_LOG2)'(1);

  state_t               r_state;
  state_t               w_next;
  logic [RING_LOG2-1:0] r_wr_ptr;
  logic [RING_LOG2-1:0] r_rd_ptr;
  logic [RING_LOG2:0]   r_fill;
  logic [7:0]           r_rd_out;
  logic [15:0]          r_run;
  logic                 r_last_wr;
  logic                 r_cmd_done;
  logic                 r_dat_done;
  logic                 r_ib_re;
  logic [2:0]           r_app_cmd;
  logic [29:0]          r_app_addr;
  logic [255:0]         r_wdf_data;

  logic [8:0] w_credit;
  logic       w_wr_ok;
  logic       w_rd_ok;
  logic       w_pick_wr;
  logic       w_start_wr;
  logic       w_start_rd;
  logic       w_app_en;
  logic       w_wdf_wren;
  logic       w_cmd_acc;
  logic       w_dat_acc;
  logic       w_wr_done;
  logic       w_rd_acc;

  // Full ring is exactly the top fill bit set.
  assign w_credit = {2'b00, bus.ob_count} + {1'b0, r_rd_out};
  assign w_wr_ok  = bus.calib_done & bus.enable & bus.ib_valid
                  & ~r_fill[RING_LOG2];
  assign w_rd_ok  = bus.calib_done & bus.enable & (r_fill != '0)
                  & (w_credit < CAP);

  always_comb begin
    w_pick_wr = w_wr_ok;
    if (w_wr_ok && w_rd_ok)
      w_pick_wr = (r_run < RUN_MAX) ? r_last_wr : ~r_last_wr;
  end

  assign w_start_wr = (r_state == IDLE) & w_wr_ok & w_pick_wr;
  assign w_start_rd = (r_state == IDLE) & w_rd_ok & ~w_pick_wr;

  assign w_cmd_acc = w_app_en & bus.app_rdy;
  assign w_dat_acc = w_wdf_wren & bus.app_wdf_rdy;
  assign w_wr_done = (r_state == WR_ISSUE)
                   & (r_cmd_done | w_cmd_acc)
                   & (r_dat_done | w_dat_acc);
  assign w_rd_acc  = (r_state == RD_ISSUE) & bus.app_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_wr)      w_next = WR_ISSUE;
        else if (w_start_rd) w_next = RD_ISSUE;
      end
      WR_ISSUE: if (w_wr_done) w_next = IDLE;
      RD_ISSUE: if (w_rd_acc)  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Command and data halves of a write retire independently.
  always_comb begin
    w_app_en   = 1'b0;
    w_wdf_wren = 1'b0;
    unique case (r_state)
      WR_ISSUE: begin
        w_app_en   = ~r_cmd_done;
        w_wdf_wren = ~r_dat_done;
      end
      RD_ISSUE: w_app_en = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_rd_out   <= '0;
      r_run      <= '0;
      r_last_wr  <= 1'b0;
      r_cmd_done <= 1'b0;
      r_dat_done <= 1'b0;
      r_ib_re    <= 1'b0;
      r_app_cmd  <= '0;
      r_app_addr <= '0;
      r_wdf_data <= '0;
    end else begin
      r_ib_re <= w_start_wr;
      if (w_start_wr) begin
        r_app_cmd  <= 3'b000;
        r_app_addr <= BASE + 30'(r_wr_ptr) * STEP;
        r_wdf_data <= bus.ib_data;
      end else if (w_start_rd) begin
        r_app_cmd  <= 3'b001;
        r_app_addr <= BASE + 30'(r_rd_ptr) * STEP;
      end
      if (w_start_wr || w_start_rd) begin
        r_last_wr <= w_start_wr;
        if (w_start_wr == r_last_wr) begin
          if (r_run < RUN_MAX) r_run <= r_run + 16'd1;
        end else begin
          r_run <= 16'd1;
        end
      end
      if (w_start_wr)     r_cmd_done <= 1'b0;
      else if (w_cmd_acc) r_cmd_done <= 1'b1;
      if (w_start_wr)     r_dat_done <= 1'b0;
      else if (w_dat_acc) r_dat_done <= 1'b1;
      if (w_wr_done) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_fill   <= r_fill + FILL_ONE;
      end else if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_fill   <= r_fill - FILL_ONE;
      end
      case ({w_rd_acc, bus.app_rd_data_valid})
        2'b10:   r_rd_out <= r_rd_out + 8'd1;
        2'b01:   r_rd_out <= r_rd_out - 8'd1;
        default: ;
      endcase
    end
  end

`ifdef DDR3_SCHED_STATS_EN
  logic [31:0] r_wr_tot;
  logic [31:0] r_rd_tot;
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_tot <= '0;
      r_rd_tot <= '0;
      r_stall  <= '0;
    end else begin
      if (w_cmd_acc && r_state == WR_ISSUE && r_wr_tot != '1)
        r_wr_tot <= r_wr_tot + 32'd1;
      if (w_rd_acc && r_rd_tot != '1)
        r_rd_tot <= r_rd_tot + 32'd1;
      if (w_app_en && !bus.app_rdy && r_stall != '1)
        r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.wr_cmd_total = r_wr_tot;
  assign bus.rd_cmd_total = r_rd_tot;
  assign bus.stall_cycles = r_stall;
`else
  assign bus.wr_cmd_total = '0;
  assign bus.rd_cmd_total = '0;
  assign bus.stall_cycles = '0;
`endif

  assign bus.app_en         = w_app_en;
  assign bus.app_cmd        = r_app_cmd;
  assign bus.app_addr       = r_app_addr;
  assign bus.app_wdf_wren   = w_wdf_wren;
  assign bus.app_wdf_end    = w_wdf_wren;
  assign bus.app_wdf_data   = r_wdf_data;
  assign bus.app_wdf_mask   = '0;
  assign bus.ib_re          = r_ib_re;
  assign bus.ob_we          = bus.app_rd_data_valid;
  assign bus.ob_data        = bus.app_rd_data;
  assign bus.fill_level     = r_fill;
  assign bus.rd_outstanding = r_rd_out;
  assign bus.busy           = (r_state != IDLE);

endmodule

// File: doc/ddr3_ring_scheduler.md
Name: ddr3_ring_scheduler

Overview:
- Sequences the MIG DDR3 user interface (256-bit app data, 30-bit app_addr) as a ring buffer between the ADC acquisition input FIFO (256-bit read side, first-word-fall-through) and the host output FIFO (256-bit write side).
- Arbitrates write and read commands, generates ring addresses, tracks ring occupancy, and limits outstanding reads by output-FIFO credit.
- Sits between the pipe FIFOs and the MIG user interface, clocked by ui_clk.

Parameters:
- RING_LOG2, 20, ring depth = 2^RING_LOG2 words of 256 bits.
- ADDR_BASE, 0, app_addr of ring word 0; must be a multiple of 8.
- ADDR_STEP, 8, app_addr increment per 256-bit word (BL8 on a 32-bit bus).
- MAX_RUN, 16, maximum consecutive same-type commands while the other type is eligible.
- OB_CAP, 120, output FIFO capacity in 256-bit words available as read credit.

Ports:
- clk  in  1  MIG ui_clk
- rst  in  1  asynchronous, active-high reset
- calib_done  in  1  MIG init_calib_complete
- enable  in  1  allows new commands
- ib_valid  in  1  input FIFO head word valid
- ib_data  in  256  input FIFO head word
- ib_re  out  1  input FIFO pop
- ob_count  in  7  output FIFO write-side word count
- ob_we  out  1  output FIFO push
- ob_data  out  256  output FIFO data
- app_rdy  in  1  MIG command ready
- app_en  out  1  MIG command valid
- app_cmd  out  3  3'b000 = write, 3'b001 = read
- app_addr  out  30  MIG address
- app_wdf_rdy  in  1  MIG write-data ready
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  equals app_wdf_wren
- app_wdf_data  out  256  write data
- app_wdf_mask  out  32  tied to 0
- app_rd_data  in  256  read data
- app_rd_data_valid  in  1  read data valid
- fill_level  out  RING_LOG2+1  words currently stored in the ring
- rd_outstanding  out  8  read commands accepted but not yet returned
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, active-high) clears:
  - state to IDLE
  - wr_ptr, rd_ptr, fill_level, rd_outstanding, run counter, last_type (= read) to 0
  - app_en, app_wdf_wren, ib_re, app_cmd, app_addr, app_wdf_data to 0
- Reset mid-transaction abandons the command; the ring contents are treated as lost.
- Eligibility:
  - wr_ok = calib_done & enable & ib_valid & (fill_level < 2^RING_LOG2).
  - rd_ok = calib_done & enable & (fill_level > 0) & (ob_count + rd_outstanding < OB_CAP).
- IDLE arbitration:
  - Only one eligible: take it.
  - Both eligible: continue last_type while run < MAX_RUN, otherwise switch.
  - The run counter resets to 1 on a type change and increments on a repeat.
- WR_ISSUE (entered registered):
  - app_en=1, app_cmd=000, app_addr=ADDR_BASE+wr_ptr*ADDR_STEP, app_wdf_wren=app_wdf_end=1, app_wdf_data=ib_data captured on entry.
  - ib_re pulses for exactly 1 cycle on entry.
  - app_en drops the cycle after app_rdy is seen high; app_wdf_wren drops the cycle after app_wdf_rdy is seen high; the two may be accepted in different cycles.
  - When both have been accepted: wr_ptr+1 (wraps 2^RING_LOG2-1 → 0), fill_level+1, return to IDLE.
- RD_ISSUE:
  - app_en=1, app_cmd=001, app_addr=ADDR_BASE+rd_ptr*ADDR_STEP.
  - On app_rdy: rd_ptr+1 (wraps), fill_level-1, rd_outstanding+1, return to IDLE.
- Minimum 1 IDLE cycle between commands, so back-to-back throughput is 1 command per 2 cycles when app_rdy is constant.
- Read return: ob_we=app_rd_data_valid and ob_data=app_rd_data, combinational passthrough with zero latency; each valid decrements rd_outstanding.
- Counter updates:
  - A read accept and a data return in the same cycle leave rd_outstanding unchanged.
  - A write accept and a read accept cannot coincide (single issue state).
- enable or calib_done falling mid-command: the current command completes; no new command starts.
- No command is ever retracted once app_en is asserted.
- app_addr width rule: the product is computed in 30 bits; overflow above 30 bits is a configuration error, not handled.

Optional Feature:
- Macro DDR3_SCHED_STATS_EN.
- Defined:
  - Adds outputs wr_cmd_total[31:0], rd_cmd_total[31:0] (accepted commands) and stall_cycles[31:0] (cycles with app_en=1 & app_rdy=0).
  - All three saturate at 32'hFFFFFFFF and are cleared by rst.
- Undefined: the ports remain and are driven to 0; no counter logic.

Test Plan:
- Reset with calib_done=0, ib_valid=1 → no app_en for 100 cycles; all outputs 0; fill_level=0.
- calib_done=1, enable=1, 4 words pushed, app_rdy=app_wdf_rdy=1, no reads possible (ob_count=120) → 4 writes at app_addr 0, 8, 16, 24; ib_re 4 single-cycle pulses; fill_level=4.
- Then ob_count=0 → 4 reads at 0, 8, 16, 24; rd_outstanding reaches 4; returning 4 valids makes rd_outstanding=0 and produces ob_we×4 with matching data; fill_level=0.
- RING_LOG2=2, 5 words offered with no reads → 4 writes accepted, 5th stalled (fill_level=4); one read then lets the 5th write go to app_addr 0 (wrap).
- Both types continuously eligible, MAX_RUN=16 → command pattern is 16 writes, 16 reads, repeating.
- app_rdy held low 10 cycles during WR_ISSUE while app_wdf_rdy=1 → app_wdf_wren drops after 1 cycle and app_en stays high until app_rdy; with DDR3_SCHED_STATS_EN, stall_cycles=10.
